// File: rtl/rv_plic_pkg.sv
// rv_plic_pkg -- shared types for the PLIC interrupt gateway.
//
// Contents:
//   gw_state_e : per-source gateway FSM state (IDLE, PEND, ACTIVE).
//                The encoding 2'b11 is unused and treated as illegal.
//
// Optional feature macro: RV_PLIC_EDGE_CNT_EN (see rv_plic_gw_cell).

package rv_plic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    PEND   = 2'b01,
    ACTIVE = 2'b10
  } gw_state_e;

endpackage

// File: rtl/rv_plic_gw_cell.sv
// rv_plic_gw_cell -- interrupt gateway for one PLIC source.
//
// Ports:
//   clk_i       : clock
//   rst_i       : synchronous, active-high reset
//   src_i       : raw interrupt line (already synchronous to clk_i)
//   le_i        : 1 = rising-edge triggered, 0 = level (high) triggered
//   claim_i     : one-cycle claim pulse, honoured only in PEND
//   complete_i  : one-cycle completion pulse, honoured only in ACTIVE
//   ip_o        : interrupt pending  (state == PEND)
//   ia_o        : interrupt active   (state == ACTIVE)
//   state_o     : current FSM state, for debug/observation
//
// Handshake: claim_i and complete_i are single-cycle strobes with no
// back-pressure. A strobe that arrives in a state that cannot accept it is
// dropped; the current state alone decides which strobe is honoured.
//
// Optional feature macro RV_PLIC_EDGE_CNT_EN: in edge mode, rising edges
// arriving while PEND or ACTIVE are counted (saturating, EDGE_CNT_W bits) and
// replayed as further PEND rounds after each completion. Without the macro
// such edges are dropped and no counter exists.

module rv_plic_gw_cell
  import rv_plic_pkg::*;
#(
  parameter int EDGE_CNT_W = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       src_i,
  input  logic       le_i,
  input  logic       claim_i,
  input  logic       complete_i,
  output logic       ip_o,
  output logic       ia_o,
  output logic [1:0] state_o
);

  gw_state_e state_q, state_d;
  logic      src_q;
  logic      edge_s;
  logic      trig;
  logic      replay;

  if (EDGE_CNT_W < 1) begin : g_bad_cnt_w
    $error("EDGE_CNT_W must be at least 1");
  end

  assign edge_s = src_i & ~src_q;
  assign trig   = le_i ? edge_s : src_i;

`ifdef RV_PLIC_EDGE_CNT_EN
  logic [EDGE_CNT_W-1:0] cnt_q;
  logic [EDGE_CNT_W-1:0] cnt_sat;

  // Count the current-cycle edge first (saturating), so a completion that
  // coincides with a new edge still sees that edge.
  always_comb begin
    cnt_sat = cnt_q;
    if (edge_s && (cnt_q != {EDGE_CNT_W{1'b1}})) cnt_sat = cnt_q + 1'b1;
  end

  assign replay = le_i && (cnt_sat != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (!le_i) begin
      cnt_q <= '0;
    end else if (state_q == ACTIVE && complete_i) begin
      cnt_q <= replay ? (cnt_sat - 1'b1) : '0;
    end else if (state_q == PEND || state_q == ACTIVE) begin
      cnt_q <= cnt_sat;
    end
  end
`else
  assign replay = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (trig)       state_d = PEND;
      PEND:    if (claim_i)    state_d = ACTIVE;
      ACTIVE:  if (complete_i) state_d = replay ? PEND : IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_i;
    end
  end

  // Outputs decode only the state register: no input-to-output path.
  assign ip_o    = (state_q == PEND);
  assign ia_o    = (state_q == ACTIVE);
  assign state_o = state_q;

  a_legal_state : assert property (@(posedge clk_i) state_q != 2'b11);
  a_ip_ia_excl  : assert property (@(posedge clk_i) !(ip_o && ia_o));

endmodule

// File: rtl/rv_plic_gateway.sv
// rv_plic_gateway -- array of independent PLIC interrupt gateways.
//
// Ports:
//   clk_i      : clock
//   rst_i      : synchronous, active-high reset
//   src_i      : [N_SOURCE] raw interrupt lines
//   le_i       : [N_SOURCE] 1 = edge, 0 = level
//   claim_i    : [N_SOURCE] claim pulses
//   complete_i : [N_SOURCE] completion pulses
//   ip_o       : [N_SOURCE] interrupt pending
//   ia_o       : [N_SOURCE] interrupt active
//   gw_state_o : [2*N_SOURCE] debug view, source i at bits [2i+1:2i]
//
// Optional feature macro RV_PLIC_EDGE_CNT_EN enables per-source edge counting
// and replay inside each cell.

module rv_plic_gateway #(
  parameter int N_SOURCE   = 32,
  parameter int EDGE_CNT_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_SOURCE-1:0]   src_i,
  input  logic [N_SOURCE-1:0]   le_i,
  input  logic [N_SOURCE-1:0]   claim_i,
  input  logic [N_SOURCE-1:0]   complete_i,
  output logic [N_SOURCE-1:0]   ip_o,
  output logic [N_SOURCE-1:0]   ia_o,
  output logic [2*N_SOURCE-1:0] gw_state_o
);

  for (genvar i = 0; i < N_SOURCE; i++) begin : g_cell
    rv_plic_gw_cell #(
      .EDGE_CNT_W (EDGE_CNT_W)
    ) u_cell (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .src_i      (src_i[i]),
      .le_i       (le_i[i]),
      .claim_i    (claim_i[i]),
      .complete_i (complete_i[i]),
      .ip_o       (ip_o[i]),
      .ia_o       (ia_o[i]),
      .state_o    (gw_state_o[2*i+1:2*i])
    );
  end

endmodule

// File: tb/tb_rv_plic_gateway.sv
module tb_rv_plic_gateway;

  localparam int N = 32;

`ifdef RV_PLIC_EDGE_CNT_EN
  localparam int REPLAY_3 = 3;
  localparam int REPLAY_5 = 3;  // EDGE_CNT_W = 2 saturates at 3
`else
  localparam int REPLAY_3 = 0;
  localparam int REPLAY_5 = 0;
`endif

  logic           clk;
  logic           rst;
  logic [N-1:0]   src;
  logic [N-1:0]   le;
  logic [N-1:0]   claim;
  logic [N-1:0]   complete;
  logic [N-1:0]   ip;
  logic [N-1:0]   ia;
  logic [2*N-1:0] gw_state;

  int vectors;
  int miscompares;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rv_plic_gateway #(
    .N_SOURCE   (N),
    .EDGE_CNT_W (2)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .src_i      (src),
    .le_i       (le),
    .claim_i    (claim),
    .complete_i (complete),
    .ip_o       (ip),
    .ia_o       (ia),
    .gw_state_o (gw_state)
  );

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_claim(input logic [N-1:0] m);
    claim = m;
    tick();
    claim = '0;
  endtask

  task automatic pulse_complete(input logic [N-1:0] m);
    complete = m;
    tick();
    complete = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    vectors++;
    if (ip !== '0 || ia !== '0) begin
      miscompares++;
      $display("FAIL reset_out: ip=%h ia=%h required 0/0", ip, ia);
    end
    vectors++;
    if (gw_state !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got %h required 0", gw_state);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_level();
    le[3] = 1'b0;
    src[3] = 1'b1;
    tick();
    vectors++;
    if (ip !== 32'h8 || ia !== 32'h0) begin
      miscompares++;
      $display("FAIL level_pend: ip=%h ia=%h required 8/0", ip, ia);
    end
    tick();
    tick();
    pulse_claim(32'h8);
    vectors++;
    if (ip !== 32'h0 || ia !== 32'h8) begin
      miscompares++;
      $display("FAIL level_claim: ip=%h ia=%h required 0/8", ip, ia);
    end
    tick();
    tick();
    pulse_complete(32'h8);
    vectors++;
    if (ip !== 32'h0 || ia !== 32'h0 || gw_state[7:6] !== 2'b00) begin
      miscompares++;
      $display("FAIL level_complete: ip=%h ia=%h st=%b required 0/0/00", ip, ia, gw_state[7:6]);
    end
    tick();
    vectors++;
    if (ip !== 32'h8) begin
      miscompares++;
      $display("FAIL level_repend: ip=%h required 8", ip);
    end
    src[3] = 1'b0;
    tick();
    tick();
    vectors++;
    if (ip !== 32'h8 || ia !== 32'h0) begin
      miscompares++;
      $display("FAIL level_drop_holds: ip=%h ia=%h required 8/0", ip, ia);
    end
    pulse_claim(32'h8);
    pulse_complete(32'h8);
    tick();
    vectors++;
    if (ip !== 32'h0 || ia !== 32'h0) begin
      miscompares++;
      $display("FAIL level_done: ip=%h ia=%h required 0/0", ip, ia);
    end
  endtask

  task automatic test_edge();
    int rises;
    logic prev;
    le[0] = 1'b1;
    src[0] = 1'b1;
    tick();
    src[0] = 1'b0;
    vectors++;
    if (ip !== 32'h1) begin
      miscompares++;
      $display("FAIL edge_pulse: ip=%h required 1", ip);
    end
    pulse_claim(32'h1);
    pulse_complete(32'h1);
    tick();
    vectors++;
    if (ip !== 32'h0 || ia !== 32'h0) begin
      miscompares++;
      $display("FAIL edge_pulse_done: ip=%h ia=%h required 0/0", ip, ia);
    end
    // Held high for 20 cycles: only the first sample is an edge.
    rises = 0;
    prev = 1'b0;
    src[0] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ip[0] && !prev) rises++;
      prev = ip[0];
    end
    src[0] = 1'b0;
    vectors++;
    if (rises != 1 || ip !== 32'h1) begin
      miscompares++;
      $display("FAIL edge_held: rises=%0d ip=%h required 1/1", rises, ip);
    end
    pulse_claim(32'h1);
    pulse_complete(32'h1);
    tick();
    vectors++;
    if (ip !== 32'h0 || ia !== 32'h0) begin
      miscompares++;
      $display("FAIL edge_held_done: ip=%h ia=%h required 0/0", ip, ia);
    end
    le[0] = 1'b0;
  endtask

  task automatic test_spurious();
    le[5] = 1'b0;
    src[5] = 1'b1;
    tick();
    src[5] = 1'b0;
    pulse_complete(32'h20);
    vectors++;
    if (ip !== 32'h20 || ia !== 32'h0) begin
      miscompares++;
      $display("FAIL spur_complete_in_pend: ip=%h ia=%h required 20/0", ip, ia);
    end
    pulse_claim(32'h20);
    pulse_claim(32'h20);
    vectors++;
    if (ip !== 32'h0 || ia !== 32'h20) begin
      miscompares++;
      $display("FAIL spur_claim_in_active: ip=%h ia=%h required 0/20", ip, ia);
    end
    pulse_complete(32'h20);
    vectors++;
    if (ip !== 32'h0 || ia !== 32'h0) begin
      miscompares++;
      $display("FAIL spur_complete: ip=%h ia=%h required 0/0", ip, ia);
    end
    src[5] = 1'b1;
    tick();
    src[5] = 1'b0;
    claim[5] = 1'b1;
    complete[5] = 1'b1;
    tick();
    claim = '0;
    complete = '0;
    vectors++;
    if (ip !== 32'h0 || ia !== 32'h20) begin
      miscompares++;
      $display("FAIL spur_both_in_pend: ip=%h ia=%h required 0/20", ip, ia);
    end
    pulse_complete(32'h20);
    vectors++;
    if (ia !== 32'h0 || ip !== 32'h0) begin
      miscompares++;
      $display("FAIL spur_final: ip=%h ia=%h required 0/0", ip, ia);
    end
  endtask

  task automatic test_edge_replay(input int n_edges, input int exp_replays);
    le[2] = 1'b1;
    src[2] = 1'b1;
    tick();
    src[2] = 1'b0;
    pulse_claim(32'h4);
    for (int e = 0; e < n_edges; e++) begin
      src[2] = 1'b1;
      tick();
      src[2] = 1'b0;
      tick();
    end
    vectors++;
    if (ip !== 32'h0 || ia !== 32'h4) begin
      miscompares++;
      $display("FAIL replay_active_%0d: ip=%h ia=%h required 0/4", n_edges, ip, ia);
    end
    pulse_complete(32'h4);
    for (int r = 0; r < exp_replays; r++) begin
      vectors++;
      if (ip !== 32'h4 || ia !== 32'h0) begin
        miscompares++;
        $display("FAIL replay_round_%0d_%0d: ip=%h ia=%h required 4/0", n_edges, r, ip, ia);
      end
      pulse_claim(32'h4);
      pulse_complete(32'h4);
    end
    tick();
    vectors++;
    if (ip !== 32'h0 || ia !== 32'h0) begin
      miscompares++;
      $display("FAIL replay_idle_%0d: ip=%h ia=%h required 0/0", n_edges, ip, ia);
    end
    le[2] = 1'b0;
  endtask

  task automatic test_reset_mid();
    le = 32'h0000_F000;
    src[15:8] = 8'hFF;
    tick();
    vectors++;
    if (ip !== 32'h0000_FF00) begin
      miscompares++;
      $display("FAIL mid_pend: ip=%h required 0000ff00", ip);
    end
    src[15:12] = 4'h0;
    src[11] = 1'b0;
    pulse_claim(32'h0000_3300);
    vectors++;
    if (ip !== 32'h0000_CC00 || ia !== 32'h0000_3300) begin
      miscompares++;
      $display("FAIL mid_mixed: ip=%h ia=%h required cc00/3300", ip, ia);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if (ip !== '0 || ia !== '0 || gw_state !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: ip=%h ia=%h st=%h required 0", ip, ia, gw_state);
    end
    rst = 1'b0;
    tick();
    tick();
    vectors++;
    if (ip !== 32'h0000_0700 || ia !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_after_reset: ip=%h ia=%h required 0700/0", ip, ia);
    end
    src = '0;
    pulse_claim(32'h0000_0700);
    pulse_complete(32'h0000_0700);
    tick();
    vectors++;
    if (ip !== 32'h0 || ia !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_cleanup: ip=%h ia=%h required 0/0", ip, ia);
    end
    le = '0;
  endtask

  task automatic test_parallel();
    le = 32'hAAAA_AAAA;
    src = '1;
    tick();
    src = '0;
    vectors++;
    if (ip !== 32'hFFFF_FFFF || ia !== 32'h0) begin
      miscompares++;
      $display("FAIL par_all_pend: ip=%h ia=%h required ffffffff/0", ip, ia);
    end
    pulse_claim(32'h5555_5555);
    vectors++;
    if (ip !== 32'hAAAA_AAAA || ia !== 32'h5555_5555) begin
      miscompares++;
      $display("FAIL par_even_claim: ip=%h ia=%h required aaaaaaaa/55555555", ip, ia);
    end
    vectors++;
    if (gw_state[3:0] !== 4'b0110) begin
      miscompares++;
      $display("FAIL par_state: got %b required 0110", gw_state[3:0]);
    end
    claim = 32'hAAAA_AAAA;
    complete = 32'h5555_5555;
    tick();
    claim = '0;
    complete = '0;
    vectors++;
    if (ip !== 32'h0 || ia !== 32'hAAAA_AAAA) begin
      miscompares++;
      $display("FAIL par_swap: ip=%h ia=%h required 0/aaaaaaaa", ip, ia);
    end
    pulse_complete(32'hAAAA_AAAA);
    tick();
    vectors++;
    if (ip !== 32'h0 || ia !== 32'h0) begin
      miscompares++;
      $display("FAIL par_done: ip=%h ia=%h required 0/0", ip, ia);
    end
    le = '0;
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    src = '0;
    le = '0;
    claim = '0;
    complete = '0;
    test_reset();
    test_level();
    test_edge();
    test_spurious();
    test_edge_replay(3, REPLAY_3);
    test_edge_replay(5, REPLAY_5);
    test_reset_mid();
    test_parallel();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
